// File: rtl/e_div_unit.sv
// e_div_unit: multi-cycle integer divide/remainder unit for the E stage.
//
// Restoring division on unsigned magnitudes, one quotient bit per cycle,
// with sign fix-up applied when the result is written.
//
// Ports
//   clk_i          : clock, rising edge
//   rst_i          : synchronous active-high reset
//   E_valid_i      : E-stage instruction is a valid divide/remainder op
//   E_funct3_i     : 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   E_src1_i       : dividend
//   E_src2_i       : divisor
//   E_flush_i      : E-stage bubble, kills the in-flight op
//   E_stall_req_o  : stall request to hazard control (combinational)
//   E_div_done_o   : result valid this cycle
//   E_div_result_o : registered quotient or remainder, held until next DONE
//
// Optional build macro
//   DIV_ZERO_FAST_EN : a zero divisor skips CALC and finishes one cycle
//                      after accept. When undefined, divide-by-zero runs the
//                      full XLEN+1 cycle path and yields the same result.
//
// State | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for an op; the accept cycle is spent here
// CALC  | one restoring-division step per cycle, counter counts down
// DONE  | result register valid, done pulse; always returns to IDLE

module e_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            E_valid_i,
  input  logic [2:0]      E_funct3_i,
  input  logic [XLEN-1:0] E_src1_i,
  input  logic [XLEN-1:0] E_src2_i,
  input  logic            E_flush_i,
  output logic            E_stall_req_o,
  output logic            E_div_done_o,
  output logic [XLEN-1:0] E_div_result_o
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] divisor;
  logic [1:0]      funct3_q;
  logic            sign1_q;
  logic            sign2_q;
  logic            div_zero_q;
  logic [XLEN-1:0] result_q;

  // Bit 2 of funct3 only distinguishes M-extension groups; E_valid_i already
  // qualifies the op as a divide.
  logic unused_funct3;
  assign unused_funct3 = E_funct3_i[2];

  logic            accept;
  logic            op_signed;
  logic            sign1;
  logic            sign2;
  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;

  assign accept    = (state == IDLE) & E_valid_i & ~E_flush_i;
  assign op_signed = ~E_funct3_i[0];
  assign sign1     = op_signed & E_src1_i[XLEN-1];
  assign sign2     = op_signed & E_src2_i[XLEN-1];
  assign mag1      = sign1 ? (~E_src1_i + 1'b1) : E_src1_i;
  assign mag2      = sign2 ? (~E_src2_i + 1'b1) : E_src2_i;

  // One restoring step. The partial remainder stays below the divisor, so
  // the borrow out of the (XLEN+1)-bit subtract decides the quotient bit.
  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   diff;
  logic            q_bit;
  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] quo_next;

  assign rem_shift = {rem, quo[XLEN-1]};
  assign diff      = rem_shift - {1'b0, divisor};
  assign q_bit     = ~diff[XLEN];
  assign rem_next  = q_bit ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
  assign quo_next  = {quo[XLEN-2:0], q_bit};

  // Sign fix-up. A zero divisor leaves the all-ones quotient unsigned and the
  // remainder equal to |dividend| re-signed, i.e. the dividend itself.
  // Most-negative / -1 falls out naturally: magnitude 2^(XLEN-1), negated.
  logic            neg_q;
  logic            neg_r;
  logic [XLEN-1:0] q_final;
  logic [XLEN-1:0] r_final;
  logic [XLEN-1:0] res_final;

  assign neg_q     = ~funct3_q[0] & (sign1_q ^ sign2_q) & ~div_zero_q;
  assign neg_r     = ~funct3_q[0] & sign1_q;
  assign q_final   = neg_q ? (~quo_next + 1'b1) : quo_next;
  assign r_final   = neg_r ? (~rem_next + 1'b1) : rem_next;
  assign res_final = funct3_q[1] ? r_final : q_final;

`ifdef DIV_ZERO_FAST_EN
  logic            src2_zero;
  logic [XLEN-1:0] zero_result;
  assign src2_zero   = (E_src2_i == '0);
  assign zero_result = E_funct3_i[1] ? E_src1_i : '1;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      count      <= '0;
      quo        <= '0;
      rem        <= '0;
      divisor    <= '0;
      funct3_q   <= '0;
      sign1_q    <= 1'b0;
      sign2_q    <= 1'b0;
      div_zero_q <= 1'b0;
      result_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            funct3_q   <= E_funct3_i[1:0];
            sign1_q    <= sign1;
            sign2_q    <= sign2;
            div_zero_q <= (E_src2_i == '0);
            quo        <= mag1;
            rem        <= '0;
            divisor    <= mag2;
            count      <= CW'(XLEN);
`ifdef DIV_ZERO_FAST_EN
            if (src2_zero) begin
              state    <= DONE;
              count    <= '0;
              result_q <= zero_result;
            end else begin
              state <= CALC;
            end
`else
            state <= CALC;
`endif
          end
        end
        CALC: begin
          if (E_flush_i) begin
            state <= IDLE;
            count <= '0;
          end else begin
            quo   <= quo_next;
            rem   <= rem_next;
            count <= count - 1'b1;
            if (count == CW'(1)) begin
              state    <= DONE;
              result_q <= res_final;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign E_stall_req_o  = ~rst_i & (accept | ((state == CALC) & ~E_flush_i));
  assign E_div_done_o   = ~rst_i & (state == DONE) & ~E_flush_i;
  assign E_div_result_o = result_q;

endmodule

// File: tb/tb_e_div_unit.sv
// Self-checking bench for e_div_unit (XLEN = 32).
// Expected results come from a behavioural reference and go through a
// scoreboard queue; latency and stall length are measured per op.
// Honours DIV_ZERO_FAST_EN for the divide-by-zero latency.

module tb_e_div_unit;

  localparam int XLEN = 32;
`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = XLEN + 1;
`endif
  localparam int NLAT = XLEN + 1;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            E_valid_i;
  logic [2:0]      E_funct3_i;
  logic [XLEN-1:0] E_src1_i;
  logic [XLEN-1:0] E_src2_i;
  logic            E_flush_i;
  logic            E_stall_req_o;
  logic            E_div_done_o;
  logic [XLEN-1:0] E_div_result_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] last_res = '0;

  e_div_unit #(.XLEN(XLEN)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .E_valid_i      (E_valid_i),
    .E_funct3_i     (E_funct3_i),
    .E_src1_i       (E_src1_i),
    .E_src2_i       (E_src2_i),
    .E_flush_i      (E_flush_i),
    .E_stall_req_o  (E_stall_req_o),
    .E_div_done_o   (E_div_done_o),
    .E_div_result_o (E_div_result_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return f[1] ? 32'd0 : 32'h8000_0000;
    if (!f[0]) return f[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return f[1] ? a % b : a / b;
  endfunction

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Starts an op right after a rising edge and follows it to its done pulse.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat);
    int  lat    = 0;
    int  stalls = 0;
    bit  seen   = 0;
    logic [XLEN-1:0] e;
    E_valid_i  = 1'b1;
    E_funct3_i = f;
    E_src1_i   = a;
    E_src2_i   = b;
    exp_q.push_back(ref_div(f, a, b));
    for (int k = 0; k <= NLAT + 4 && !seen; k++) begin
      @(negedge clk_i);
      if (E_div_done_o) begin
        seen = 1;
        lat  = k;
        chk({tag, " stall_in_done"}, E_stall_req_o, 0);
        chk({tag, " sb_nonempty"}, exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk({tag, " result"}, E_div_result_o, e);
          last_res = e;
        end
      end else if (E_stall_req_o) begin
        stalls++;
      end
      next_cycle();
    end
    chk({tag, " done_seen"}, seen, 1);
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " stall_cycles"}, stalls, exp_lat);
    // Valid was still high during DONE; no new op may have started.
    E_valid_i = 1'b0;
    @(negedge clk_i);
    chk({tag, " post_stall"}, E_stall_req_o, 0);
    chk({tag, " post_done"}, E_div_done_o, 0);
    chk({tag, " held"}, E_div_result_o, last_res);
    next_cycle();
  endtask

  initial begin
    int done_cnt;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;

    rst_i      = 1'b1;
    E_valid_i  = 1'b1;
    E_funct3_i = 3'b101;
    E_src1_i   = 32'd9;
    E_src2_i   = 32'd3;
    E_flush_i  = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    @(negedge clk_i);
    chk("rst stall", E_stall_req_o, 0);
    chk("rst done", E_div_done_o, 0);
    chk("rst result", E_div_result_o, 0);
    next_cycle();
    rst_i     = 1'b0;
    E_valid_i = 1'b0;
    next_cycle();

    run_op("divu_100_7", 3'b101, 32'd100, 32'd7, NLAT);
    run_op("remu_100_7", 3'b111, 32'd100, 32'd7, NLAT);
    run_op("div_m7_2",   3'b100, 32'hFFFF_FFF9, 32'd2, NLAT);
    run_op("rem_m7_2",   3'b110, 32'hFFFF_FFF9, 32'd2, NLAT);
    run_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, NLAT);
    run_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, NLAT);
    run_op("divu_z",     3'b101, 32'h0000_1234, 32'd0, ZLAT);
    run_op("remu_z",     3'b111, 32'h0000_1234, 32'd0, ZLAT);
    run_op("div_m5_z",   3'b100, 32'hFFFF_FFFB, 32'd0, ZLAT);
    run_op("rem_m5_z",   3'b110, 32'hFFFF_FFFB, 32'd0, ZLAT);
    run_op("div_7_m2",   3'b100, 32'd7, 32'hFFFF_FFFE, NLAT);
    run_op("divu_100_7b", 3'b101, 32'd100, 32'd7, NLAT);

    // Flush in the 10th CALC cycle.
    E_valid_i  = 1'b1;
    E_funct3_i = 3'b100;
    E_src1_i   = 32'd1000;
    E_src2_i   = 32'd3;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      chk("flush pre_done", E_div_done_o, 0);
      next_cycle();
    end
    E_flush_i = 1'b1;
    @(negedge clk_i);
    chk("flush stall_now", E_stall_req_o, 0);
    chk("flush done_now", E_div_done_o, 0);
    next_cycle();
    E_flush_i = 1'b0;
    E_valid_i = 1'b0;
    @(negedge clk_i);
    chk("flush stall_next", E_stall_req_o, 0);
    chk("flush done_next", E_div_done_o, 0);
    chk("flush held", E_div_result_o, last_res);
    next_cycle();
    run_op("after_flush", 3'b110, 32'd1000, 32'd7, NLAT);

    // Reset in the 5th CALC cycle.
    E_valid_i  = 1'b1;
    E_funct3_i = 3'b101;
    E_src1_i   = 32'd555;
    E_src2_i   = 32'd5;
    for (int k = 0; k < 5; k++) next_cycle();
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("rst_mid stall", E_stall_req_o, 0);
    chk("rst_mid done", E_div_done_o, 0);
    next_cycle();
    rst_i     = 1'b0;
    E_valid_i = 1'b0;
    @(negedge clk_i);
    chk("rst_mid idle_stall", E_stall_req_o, 0);
    chk("rst_mid result", E_div_result_o, 0);
    done_cnt = 0;
    for (int k = 0; k < NLAT + 8; k++) begin
      next_cycle();
      @(negedge clk_i);
      if (E_div_done_o) done_cnt++;
    end
    chk("rst_mid no_done", done_cnt, 0);
    last_res = '0;
    next_cycle();
    run_op("after_rst", 3'b101, 32'd555, 32'd5, NLAT);

    for (int i = 0; i < 6; i++) begin
      f = 3'b100 | 3'($urandom_range(0, 3));
      a = $urandom;
      b = (i == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
      run_op("rand", f, a, b, (b == 32'd0) ? ZLAT : NLAT);
    end

    chk("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
